cache_invalidate_ctrl: RTL and testbench

Sequencer that performs a full cache invalidation in hardware. It accepts a one-cycle invalidate request from the cache control register block and optionally waits for the write-through buffer to drain. It then walks every line index of the valid-bit memory, clearing one line per cycle, and stalls the front-end for the whole operation. It sits between the control register block, the write-through buffer status and the tag/valid memory of the cache datapath.

---
 rtl/cache_invalidate_ctrl.sv | 101 ++++++++++
 tb/tb_cache_invalidate_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_invalidate_ctrl.sv
// cache_invalidate_ctrl
// Hardware full-cache invalidation sequencer. It accepts a one-cycle request
// and optionally waits for the write-through buffer to drain. It then clears
// one valid bit per cycle across all 2^LINE_OFF_W lines, holding the front-end
// off the cache for the whole operation. A one-deep pending flag lets a
// request that arrives mid-operation run immediately after DONE, with no IDLE
// cycle in between.
//
// Handshake: inv_req is a single-cycle pulse with no ready/ack. It is always
// accepted, either by starting an operation or by setting the pending flag.
// Requests arriving while pending is already set merge into that pending
// request. done is a single-cycle pulse and needs no acknowledge.

module cache_invalidate_ctrl #(
  parameter int LINE_OFF_W = 7,
  parameter bit WAIT_WTBUF = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inv_req,
  input  logic                  wtbuf_empty,
  output logic                  fe_stall,
  output logic                  busy,
  output logic                  inv_en,
  output logic [LINE_OFF_W-1:0] inv_addr,
  output logic                  done,
  output logic [15:0]           inv_cnt,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // First active state of an invalidation; this depends on whether the
  // write-through buffer must drain first.
  localparam state_t START_ST = WAIT_WTBUF ? S_DRAIN : S_SWEEP;

  localparam logic [LINE_OFF_W-1:0] LAST_IDX = '1;
  localparam logic [15:0]           CNT_MAX  = 16'hFFFF;

  state_t                state_q;
  logic [LINE_OFF_W-1:0] idx_q;
  logic                  pend_q;
  logic [15:0]           inv_cnt_q;

  // Sequencer state, line index, pending flag and saturating completion count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      inv_cnt_q <= '0;
    end else begin
      // The counter is rewritten with its own value every cycle unless DONE bumps it.
      inv_cnt_q <= inv_cnt_q;
      case (state_q)
        S_IDLE: begin
          idx_q  <= '0;
          pend_q <= 1'b0;
          if (inv_req) state_q <= START_ST;
        end
        S_DRAIN: begin
          if (inv_req)     pend_q  <= 1'b1;
          if (wtbuf_empty) state_q <= S_SWEEP;
        end
        S_SWEEP: begin
          if (inv_req) pend_q <= 1'b1;
          // The natural wrap of the index leaves it at 0 for the next sweep.
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_q <= S_DONE;
        end
        S_DONE: begin
          if (inv_cnt_q != CNT_MAX) inv_cnt_q <= inv_cnt_q + 16'd1;
          pend_q <= 1'b0;
          if (pend_q || inv_req) state_q <= START_ST;
          else                   state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state register. fe_stall also covers the
  // request cycle itself, so no front-end access slips in before busy rises.
  always_comb begin
    busy      = (state_q == S_DRAIN) || (state_q == S_SWEEP);
    inv_en    = (state_q == S_SWEEP);
    inv_addr  = (state_q == S_SWEEP) ? idx_q : '0;
    done      = (state_q == S_DONE);
    fe_stall  = busy || (inv_req && (state_q == S_IDLE));
    inv_cnt   = inv_cnt_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_cache_invalidate_ctrl.sv
// Testbench for cache_invalidate_ctrl.
// Two instances share one clock and reset: dut_w drains the write-through
// buffer first, and dut_n sweeps immediately. Each scenario fills per-cycle
// stimulus tables. A job-level reference model turns the request and buffer
// timeline into start, drain, sweep and done intervals, and from those
// produces the expected per-cycle outputs. The DUT is then driven from the
// same tables and compared cycle by cycle.

module tb_cache_invalidate_ctrl;

  localparam int LW   = 3;
  localparam int N    = 1 << LW;
  localparam int MAXT = 160;

  logic clk;
  logic reset;

  logic req_w, emp_w, req_n, emp_n;
  logic w_stall, w_busy, w_en, w_done;
  logic n_stall, n_busy, n_en, n_done;
  logic [LW-1:0] w_addr, n_addr;
  logic [15:0]   w_cnt, n_cnt;
  logic [1:0]    w_st, n_st;

  // Selects which instance the comparison logic observes.
  logic          sel_n;
  logic          s_stall, s_busy, s_en, s_done;
  logic [LW-1:0] s_addr;
  logic [15:0]   s_cnt;

  int n_checks;
  int n_errors;

  // Stimulus tables.
  bit req_a [MAXT];
  bit emp_a [MAXT];

  // Expected per-cycle outputs from the reference model.
  bit e_busy  [MAXT];
  bit e_en    [MAXT];
  bit e_done  [MAXT];
  bit e_stall [MAXT];
  int e_addr  [MAXT];
  int e_cnt   [MAXT];

  // Observed per-cycle outputs, used for the explicit timing spot checks.
  logic          o_busy  [MAXT];
  logic          o_en    [MAXT];
  logic          o_done  [MAXT];
  logic          o_stall [MAXT];
  logic [LW-1:0] o_addr  [MAXT];
  logic [15:0]   o_cnt   [MAXT];

  cache_invalidate_ctrl #(.LINE_OFF_W(LW), .WAIT_WTBUF(1'b1)) dut_w (
    .clk(clk), .reset(reset), .inv_req(req_w), .wtbuf_empty(emp_w),
    .fe_stall(w_stall), .busy(w_busy), .inv_en(w_en), .inv_addr(w_addr),
    .done(w_done), .inv_cnt(w_cnt), .state_dbg(w_st)
  );

  cache_invalidate_ctrl #(.LINE_OFF_W(LW), .WAIT_WTBUF(1'b0)) dut_n (
    .clk(clk), .reset(reset), .inv_req(req_n), .wtbuf_empty(emp_n),
    .fe_stall(n_stall), .busy(n_busy), .inv_en(n_en), .inv_addr(n_addr),
    .done(n_done), .inv_cnt(n_cnt), .state_dbg(n_st)
  );

  assign s_stall = sel_n ? n_stall : w_stall;
  assign s_busy  = sel_n ? n_busy  : w_busy;
  assign s_en    = sel_n ? n_en    : w_en;
  assign s_done  = sel_n ? n_done  : w_done;
  assign s_addr  = sel_n ? n_addr  : w_addr;
  assign s_cnt   = sel_n ? n_cnt   : w_cnt;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    reset = 1'b0;
    req_w = 1'b0; req_n = 1'b0; emp_w = 1'b1; emp_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_stim();
    for (int x = 0; x < MAXT; x++) begin
      req_a[x] = 1'b0;
      emp_a[x] = 1'b1;
    end
  endtask

  // ---------------- reference model ----------------
  // The model works at the level of whole invalidation jobs. A job starts on
  // the cycle after an idle request, or right after DONE when a request was
  // seen during the job or in its DONE cycle. The drain lasts until the
  // first cycle in which the buffer reads empty. The sweep then covers N
  // cycles and is followed by one DONE cycle.
  task automatic build_model(input bit wait_wt, input int t_len, input int start_cnt);
    int  t, s, c, d, dn, next_start, cnt_run;
    bit  pend;
    for (int x = 0; x < MAXT; x++) begin
      e_busy[x] = 0; e_en[x] = 0; e_done[x] = 0; e_stall[x] = 0;
      e_addr[x] = 0; e_cnt[x] = 0;
    end
    t = 0;
    next_start = -1;
    while (t < t_len) begin
      if (next_start >= 0) begin
        s = next_start;
      end else begin
        while (t < t_len && !req_a[t]) t++;
        if (t >= t_len) break;
        s = t + 1;
      end
      if (wait_wt) begin
        d = s;
        while (d < t_len && !emp_a[d]) d++;
        c = d + 1;
      end else begin
        c = s;
      end
      dn = c + N;
      for (int x = s; x < dn && x < t_len; x++) e_busy[x] = 1;
      for (int k = 0; k < N; k++) begin
        if (c + k < t_len) begin
          e_en[c + k]   = 1;
          e_addr[c + k] = k;
        end
      end
      if (dn < t_len) e_done[dn] = 1;
      pend = 0;
      for (int x = s; x <= dn && x < t_len; x++) if (req_a[x]) pend = 1;
      next_start = pend ? dn + 1 : -1;
      t = dn + 1;
    end
    cnt_run = start_cnt;
    for (int x = 0; x < t_len; x++) begin
      if (x > 0 && e_done[x-1]) cnt_run = (cnt_run >= 65535) ? 65535 : cnt_run + 1;
      e_cnt[x]   = cnt_run;
      e_stall[x] = e_busy[x] | (req_a[x] & !e_busy[x] & !e_done[x]);
    end
  endtask

  // ---------------- driver + per-cycle compare ----------------
  task automatic run_scenario(input bit use_n, input int t_len, input int start_cnt,
                              input string name);
    sel_n = use_n;
    build_model(!use_n, t_len, start_cnt);
    for (int x = 0; x < t_len; x++) begin
      @(posedge clk);
      #1;
      if (use_n) begin
        req_n = req_a[x]; emp_n = emp_a[x]; req_w = 1'b0; emp_w = 1'b1;
      end else begin
        req_w = req_a[x]; emp_w = emp_a[x]; req_n = 1'b0; emp_n = 1'b1;
      end
      @(negedge clk);
      o_busy[x] = s_busy; o_en[x] = s_en; o_done[x] = s_done;
      o_stall[x] = s_stall; o_addr[x] = s_addr; o_cnt[x] = s_cnt;
      n_checks += 6;
      if (s_busy !== e_busy[x]) begin
        n_errors++;
        $display("FAIL %s busy cyc %0d got %b exp %b", name, x, s_busy, e_busy[x]);
      end
      if (s_en !== e_en[x]) begin
        n_errors++;
        $display("FAIL %s inv_en cyc %0d got %b exp %b", name, x, s_en, e_en[x]);
      end
      if (s_addr !== LW'(e_addr[x])) begin
        n_errors++;
        $display("FAIL %s inv_addr cyc %0d got %0d exp %0d", name, x, s_addr, e_addr[x]);
      end
      if (s_done !== e_done[x]) begin
        n_errors++;
        $display("FAIL %s done cyc %0d got %b exp %b", name, x, s_done, e_done[x]);
      end
      if (s_stall !== e_stall[x]) begin
        n_errors++;
        $display("FAIL %s fe_stall cyc %0d got %b exp %b", name, x, s_stall, e_stall[x]);
      end
      if (s_cnt !== 16'(e_cnt[x])) begin
        n_errors++;
        $display("FAIL %s inv_cnt cyc %0d got %h exp %h", name, x, s_cnt, 16'(e_cnt[x]));
      end
    end
    @(posedge clk);
    #1;
    req_w = 1'b0; req_n = 1'b0;
  endtask

  task automatic spot(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_dut();
    spot("reset busy_w",    16'(w_busy),  16'h0);
    spot("reset inv_en_w",  16'(w_en),    16'h0);
    spot("reset inv_addr_w",16'(w_addr),  16'h0);
    spot("reset done_w",    16'(w_done),  16'h0);
    spot("reset fe_stall_w",16'(w_stall), 16'h0);
    spot("reset inv_cnt_w", w_cnt,        16'h0);
    spot("reset inv_cnt_n", n_cnt,        16'h0);
    spot("reset state_w",   16'(w_st),    16'h0);
    // In IDLE, a request stalls the front-end within the same cycle.
    req_w = 1'b1;
    #1;
    spot("idle req fe_stall", 16'(w_stall), 16'h1);
    spot("idle req busy",     16'(w_busy),  16'h0);
    req_w = 1'b0;
  endtask

  task automatic test_basic();
    reset_dut();
    clear_stim();
    req_a[10] = 1'b1;
    run_scenario(1'b0, 30, 0, "basic");
    spot("basic fe_stall@10", 16'(o_stall[10]), 16'h1);
    spot("basic busy@10",     16'(o_busy[10]),  16'h0);
    spot("basic busy@11",     16'(o_busy[11]),  16'h1);
    spot("basic en@11",       16'(o_en[11]),    16'h0);
    spot("basic en@12",       16'(o_en[12]),    16'h1);
    spot("basic addr@19",     16'(o_addr[19]),  16'h7);
    spot("basic done@20",     16'(o_done[20]),  16'h1);
    spot("basic cnt@20",      o_cnt[20],        16'h0);
    spot("basic cnt@21",      o_cnt[21],        16'h1);
  endtask

  task automatic test_drain_hold();
    reset_dut();
    clear_stim();
    req_a[10] = 1'b1;
    for (int x = 11; x <= 15; x++) emp_a[x] = 1'b0;
    run_scenario(1'b0, 34, 0, "drain");
    spot("drain busy@16", 16'(o_busy[16]), 16'h1);
    spot("drain en@16",   16'(o_en[16]),   16'h0);
    spot("drain en@17",   16'(o_en[17]),   16'h1);
    spot("drain addr@24", 16'(o_addr[24]), 16'h7);
    spot("drain done@25", 16'(o_done[25]), 16'h1);
  endtask

  task automatic test_no_wait();
    reset_dut();
    clear_stim();
    req_a[4] = 1'b1;
    for (int x = 0; x < MAXT; x++) emp_a[x] = 1'($urandom_range(1, 0));
    run_scenario(1'b1, 20, 0, "nowait");
    spot("nowait en@5",    16'(o_en[5]),    16'h1);
    spot("nowait addr@12", 16'(o_addr[12]), 16'h7);
    spot("nowait done@13", 16'(o_done[13]), 16'h1);
    spot("nowait cnt@14",  o_cnt[14],       16'h1);
  endtask

  task automatic test_back_to_back();
    reset_dut();
    clear_stim();
    req_a[10] = 1'b1;
    req_a[15] = 1'b1;
    req_a[18] = 1'b1;
    run_scenario(1'b0, 45, 0, "b2b");
    spot("b2b done@20", 16'(o_done[20]), 16'h1);
    spot("b2b busy@20", 16'(o_busy[20]), 16'h0);
    spot("b2b busy@21", 16'(o_busy[21]), 16'h1);
    spot("b2b done@30", 16'(o_done[30]), 16'h1);
    spot("b2b busy@35", 16'(o_busy[35]), 16'h0);
    spot("b2b cnt end", o_cnt[44],       16'h2);
  endtask

  task automatic test_reset_mid();
    reset_dut();
    clear_stim();
    req_a[3] = 1'b1;
    run_scenario(1'b0, 10, 0, "midrst_pre");
    // The sampled cycle 9 showed inv_addr 4. Reset now, away from any clock edge.
    spot("midrst addr before", 16'(o_addr[9]), 16'h4);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    spot("midrst busy",     16'(w_busy),  16'h0);
    spot("midrst inv_en",   16'(w_en),    16'h0);
    spot("midrst inv_addr", 16'(w_addr),  16'h0);
    spot("midrst done",     16'(w_done),  16'h0);
    spot("midrst fe_stall", 16'(w_stall), 16'h0);
    spot("midrst inv_cnt",  w_cnt,        16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_stim();
    req_a[2] = 1'b1;
    run_scenario(1'b0, 16, 0, "midrst_post");
    spot("midrst post addr@4", 16'(o_addr[4]), 16'h0);
    spot("midrst post en@4",   16'(o_en[4]),   16'h1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      reset_dut();
      clear_stim();
      for (int x = 0; x < 140; x++) begin
        req_a[x] = (x < 80) && ($urandom_range(7, 0) == 0);
        emp_a[x] = ($urandom_range(3, 0) != 0);
      end
      run_scenario(1'(r % 2), 140, 0, (r % 2) ? "rand_n" : "rand_w");
    end
  endtask

  task automatic test_saturate();
    reset_dut();
    @(negedge clk);
    force dut_n.inv_cnt_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut_n.inv_cnt_q;
    clear_stim();
    req_a[2]  = 1'b1;
    req_a[14] = 1'b1;
    run_scenario(1'b1, 28, 65534, "sat");
    spot("sat cnt@11",  o_cnt[11], 16'hFFFE);
    spot("sat cnt@12",  o_cnt[12], 16'hFFFF);
    spot("sat cnt end", o_cnt[27], 16'hFFFF);
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    reset = 1'b0;
    req_w = 1'b0; req_n = 1'b0; emp_w = 1'b1; emp_n = 1'b1;
    sel_n = 1'b0;
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_drain_hold();
    test_no_wait();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
